alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Iterative 32x32 unsigned multiply controller that time-shares the pipeline's single ALU between the EX stage and a shift-add multiply sequence. While idle it passes EX-stage operands and opcode straight to the ALU. On a multiply request it stalls the pipeline, drives the ALU with an add each cycle for 32 iterations, and returns a 64-bit product. It sits in the EX stage, between the ID/EX pipeline register and the ALU.

## Interface
- WIDTH, 32, operand width; fixed at 32 for this design, and the counter width derives from it.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ex_A  in  32  EX-stage operand A.
- ex_B  in  32  EX-stage operand B.
- ex_Op  in  5  EX-stage ALU opcode.
- mul_start  in  1  multiply request; level, sampled only in IDLE.
- mul_kill  in  1  pipeline flush; aborts a multiply in progress.
- mul_A  in  32  multiplicand, captured on an accepted start.
- mul_B  in  32  multiplier, captured on an accepted start.
- alu_A  out  32  to ALU A.
- alu_B  out  32  to ALU B.
- alu_Op  out  5  to ALU Op.
- alu_Result  in  32  ALU Result.
- alu_Carryout  in  1  ALU Carryout (bit 32 of A+B).
- stall  out  1  holds IF/ID/EX pipeline registers.
- busy  out  1  sequencer not in IDLE.
- done  out  1  one-cycle pulse; product valid.
- prod_hi  out  32  product bits 63:32.
- prod_lo  out  32  product bits 31:0.

## Operation
- Registers:
  - mcand[31:0]
  - hi[31:0]
  - lo[31:0]; holds the multiplier initially and the product low word at the end
  - cnt[5:0]
  - state
- States:
  - IDLE
  - ITER
  - DONE
- IDLE:
  - alu_A=ex_A, alu_B=ex_B, alu_Op=ex_Op, combinational pass-through.
  - If mul_start=1 and mul_kill=0: mcand<=mul_A, lo<=mul_B, hi<=0, cnt<=0, state<=ITER.
- ITER:
  - alu_A=hi.
  - alu_B = lo[0] ? mcand : 0.
  - alu_Op=5'b00010 (add).
  - Each cycle: hi<={alu_Carryout, alu_Result[31:1]}, lo<={alu_Result[0], lo[31:1]}, cnt<=cnt+1.
  - When cnt==31 (32nd iteration), state<=DONE.
- DONE:
  - Pass-through restored, as in IDLE.
  - done=1.
  - Next state is IDLE.
  - A mul_start in DONE is ignored; the requester re-asserts it in IDLE.
- prod_hi=hi and prod_lo=lo at all times. They hold the last product until the next accepted start.
- mul_kill=1 in ITER or DONE:
  - state<=IDLE next cycle; hi/lo keep their partial values.
  - done stays 0 in the kill cycle.
  - mul_kill has priority over mul_start and over the cnt==31 transition.
- mul_start while busy is ignored; there is no queueing.
- Arithmetic: all unsigned; 65-bit {carry,hi,lo} shifts right by one per iteration. Signed MULT uses prod_lo only (low word is sign-agnostic).

## Timing
- Reset values:
  - state=IDLE; hi=0, lo=0, mcand=0, cnt=0.
  - done=0, busy=0, stall=0.
  - prod_hi=0, prod_lo=0.
  - ALU outputs equal the pass-through of ex_*.
- Reset mid-multiply: next cycle is IDLE with all registers cleared; no done pulse.
- stall = (state==IDLE & mul_start & ~mul_kill) | (state==ITER). It is combinational, so the pipeline freezes in the acceptance cycle.
- busy = (state!=IDLE).
- Latency: start accepted at edge 0; ITER occupies cycles 1..32; DONE in cycle 33 with done=1 and stall=0. The EX/MEM register captures the product in that cycle.
- Throughput: one multiply per 34 cycles minimum (accept, 32 ITER, DONE, then IDLE before the next start).
- cnt never wraps. It leaves ITER at 31, and reset or kill clears the path.
- alu_Op in ITER is always add, with no glitch from ex_Op.

## Test plan
- Reset then idle: ex_A=7, ex_B=9, ex_Op=5'b00011 -> alu_A=7, alu_B=9, alu_Op=5'b00011; stall=0, busy=0, done=0, prod=0.
- mul_A=3, mul_B=5, start one cycle -> stall high cycles 0..32; done=1 exactly at cycle 33; prod_hi=0, prod_lo=15; busy=0 at cycle 34.
- mul_A=mul_B=32'hFFFFFFFF -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001 (exercises alu_Carryout every iteration). Also mul_A=32'h80000000, mul_B=2 -> prod_hi=1, prod_lo=0.
- Start accepted; hold mul_start=1 with new operands through ITER -> the second request is ignored, a single done pulse occurs, and the product equals the first operands.
- Start 6x7, assert mul_kill at cycle 10 -> IDLE at cycle 11, no done pulse, stall=0 from cycle 11. A fresh start then yields the correct product at +33.
- Start 6x7, assert reset at cycle 20 -> all outputs at reset values next cycle, no done. A later start of 6x7 gives prod_lo=42.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-add 32x32 unsigned multiply sequencer sharing the EX-stage ALU.
// Idle/done pass EX operands to the ALU; ITER borrows it for 32 add steps.
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ex_A,
  input  logic [WIDTH-1:0] ex_B,
  input  logic [4:0]       ex_Op,
  input  logic             mul_start,
  input  logic             mul_kill,
  input  logic [WIDTH-1:0] mul_A,
  input  logic [WIDTH-1:0] mul_B,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_Op,
  input  logic [WIDTH-1:0] alu_Result,
  input  logic             alu_Carryout,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [4:0] OP_ADD = 5'b00010;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CW-1:0]    cnt;
  logic             accept;

  always_comb begin
    state_next = state;
    alu_A      = ex_A;
    alu_B      = ex_B;
    alu_Op     = ex_Op;
    stall      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (mul_start && !mul_kill) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = ITER;
        end
      end
      ITER: begin
        alu_A  = hi;
        alu_B  = lo[0] ? mcand : '0;
        alu_Op = OP_ADD;
        stall  = 1'b1;
        if (mul_kill)
          state_next = IDLE;
        else if (cnt == CW'(WIDTH - 1))
          state_next = DONE;
      end
      DONE: begin
        done       = !mul_kill;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign prod_hi = hi;
  assign prod_lo = lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mcand <= mul_A;
        lo    <= mul_B;
        hi    <= '0;
        cnt   <= '0;
      end else if (state == ITER) begin
        if (mul_kill) begin
          cnt <= '0;
        end else begin
          // {carry,hi,lo} shifts right one place per step
          hi  <= {alu_Carryout, alu_Result[WIDTH-1:1]};
          lo  <= {alu_Result[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer against a cycle-count/product model.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ex_A, ex_B, mul_A, mul_B;
  logic [4:0]  ex_Op;
  logic        mul_start, mul_kill;
  logic [31:0] alu_A, alu_B, alu_Result;
  logic [4:0]  alu_Op;
  logic        alu_Carryout;
  logic        stall, busy, done;
  logic [31:0] prod_hi, prod_lo;

  int total = 0;
  int bad   = 0;

  alu_mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .ex_A(ex_A), .ex_B(ex_B), .ex_Op(ex_Op),
    .mul_start(mul_start), .mul_kill(mul_kill), .mul_A(mul_A), .mul_B(mul_B),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op),
    .alu_Result(alu_Result), .alu_Carryout(alu_Carryout),
    .stall(stall), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo)
  );

  always #5 clk = ~clk;

  // Simple ALU: op 2 is add with carry, anything else an xor.
  always_comb begin
    if (alu_Op == 5'b00010) {alu_Carryout, alu_Result} = {1'b0, alu_A} + {1'b0, alu_B};
    else                    {alu_Carryout, alu_Result} = {1'b0, alu_A ^ alu_B};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rand_ex();
    ex_A  = $urandom;
    ex_B  = $urandom;
    ex_Op = 5'($urandom_range(0, 31));
    if (ex_Op == 5'b00010) ex_Op = 5'b00111;
  endtask

  // One multiply: start in cycle 0; optional hold of start, kill or reset at a cycle.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input int kill_cyc, input int reset_cyc);
    logic [63:0] prod;
    int ab;
    bit aborted, iter;
    prod = {32'd0, a} * {32'd0, b};
    ab = (kill_cyc > 0) ? kill_cyc : reset_cyc;
    @(posedge clk); #1;
    rand_ex();
    mul_A = a; mul_B = b; mul_start = 1'b1; mul_kill = 1'b0;
    @(negedge clk);
    check("c0_stall", stall, 1);
    check("c0_busy", busy, 0);
    check("c0_done", done, 0);
    check("c0_aluA", alu_A, ex_A);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(posedge clk); #1;
      rand_ex();
      if (hold && cyc < 33) begin
        mul_start = 1'b1; mul_A = $urandom; mul_B = $urandom;
      end else begin
        mul_start = 1'b0;
      end
      mul_kill = (kill_cyc > 0 && cyc == kill_cyc);
      reset    = (reset_cyc > 0 && cyc == reset_cyc);
      @(negedge clk);
      aborted = (ab > 0 && cyc > ab);
      iter = !aborted && cyc <= 32;
      check("stall", stall, iter);
      check("busy", busy, !aborted && cyc <= 33);
      check("done", done, !aborted && cyc == 33 && cyc != ab);
      if (iter) begin
        check("iter_op", alu_Op, 5'b00010);
      end else begin
        check("pass_op", alu_Op, ex_Op);
        check("pass_A", alu_A, ex_A);
        check("pass_B", alu_B, ex_B);
      end
      if (ab == 0 && cyc >= 33)
        check("prod", {prod_hi, prod_lo}, prod);
      if (reset_cyc > 0 && cyc == reset_cyc + 1)
        check("rst_prod", {prod_hi, prod_lo}, 64'd0);
    end
    @(posedge clk); #1;
    mul_kill = 1'b0; reset = 1'b0; mul_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mul_start = 1'b0; mul_kill = 1'b0;
    mul_A = '0; mul_B = '0; ex_A = '0; ex_B = '0; ex_Op = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ex_A = 32'd7; ex_B = 32'd9; ex_Op = 5'b00011;
    @(negedge clk);
    check("idle_aluA", alu_A, 7);
    check("idle_aluB", alu_B, 9);
    check("idle_aluOp", alu_Op, 5'b00011);
    check("idle_stall", stall, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_prod", {prod_hi, prod_lo}, 64'd0);

    do_mul(32'd3, 32'd5, 0, 0, 0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    do_mul(32'h80000000, 32'd2, 0, 0, 0);
    do_mul($urandom, $urandom, 1, 0, 0);
    do_mul(32'd6, 32'd7, 0, 10, 0);
    do_mul(32'd6, 32'd7, 0, 0, 0);
    do_mul(32'd6, 32'd7, 0, 0, 20);
    do_mul(32'd6, 32'd7, 0, 0, 0);
    do_mul(32'd9, 32'd11, 0, 33, 0);
    for (int i = 0; i < 6; i++)
      do_mul($urandom, $urandom, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
